mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu.sv | 158 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: aligns RAM requests, extracts and extends load
// data, and forwards register-writeback sidebands to the next stage.
module mem_stage_lsu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic              in_RegWrite,
  input  logic [RD_W-1:0]   in_RegDest,
  input  logic              in_MemToReg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_data,
  output logic [XLEN-1:0]   out_AluResult,
  output logic              out_RegWrite,
  output logic [RD_W-1:0]   out_RegDest,
  output logic              out_MemToReg,
  output logic              out_fault
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

  state_t           r_state;
  logic [2:0]       r_funct3;
  logic [OFF_W-1:0] r_off;
  logic             r_is_load;
  logic             r_regwrite;

  logic [OFF_W-1:0] w_off;
  logic [1:0]       w_size;
  logic             w_mem_op;
  logic             w_misalign;
  logic             w_illegal;
  logic [7:0]       w_mask8;
  logic [BE_W-1:0]  w_be;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_maddr;
  logic [XLEN-1:0]  w_rsh;
  logic [XLEN-1:0]  w_load;

  assign w_off    = addr[OFF_W-1:0];
  assign w_size   = funct3[1:0];
  assign w_mem_op = MemRead | MemWrite;
  assign in_ready = (r_state == IDLE);

  always_comb begin
    w_misalign = 1'b0;
    w_mask8    = 8'h01;
    case (w_size)
      2'd0: begin w_misalign = 1'b0;              w_mask8 = 8'h01; end
      2'd1: begin w_misalign = addr[0];           w_mask8 = 8'h03; end
      2'd2: begin w_misalign = |addr[1:0];        w_mask8 = 8'h0F; end
      default: begin w_misalign = |addr[2:0];     w_mask8 = 8'hFF; end
    endcase
    // Doubleword and LWU have no meaning on a 32-bit datapath.
    w_illegal = (MemRead && MemWrite) || (funct3 == 3'b111) || w_misalign ||
                ((XLEN == 32) && ((w_size == 2'd3) || (funct3 == 3'b110)));
    w_be    = BE_W'(w_mask8) << w_off;
    w_wdata = wdata << {w_off, 3'b000};
    w_maddr = {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  end

  always_comb begin
    w_rsh = mem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load = XLEN'($signed(w_rsh[7:0]));
      3'b001:  w_load = XLEN'($signed(w_rsh[15:0]));
      3'b010:  w_load = XLEN'($signed(w_rsh[31:0]));
      3'b100:  w_load = XLEN'(w_rsh[7:0]);
      3'b101:  w_load = XLEN'(w_rsh[15:0]);
      3'b110:  w_load = XLEN'(w_rsh[31:0]);
      default: w_load = w_rsh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_funct3      <= '0;
      r_off         <= '0;
      r_is_load     <= 1'b0;
      r_regwrite    <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_AluResult <= '0;
      out_RegWrite  <= 1'b0;
      out_RegDest   <= '0;
      out_MemToReg  <= 1'b0;
      out_fault     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            out_AluResult <= addr;
            out_RegDest   <= in_RegDest;
            out_MemToReg  <= in_MemToReg;
            out_data      <= '0;
            if (w_mem_op && w_illegal) begin
              out_valid    <= 1'b1;
              out_fault    <= 1'b1;
              out_RegWrite <= 1'b0;
            end else if (w_mem_op) begin
              out_fault  <= 1'b0;
              r_funct3   <= funct3;
              r_off      <= w_off;
              r_is_load  <= MemRead;
              r_regwrite <= in_RegWrite;
              mem_req    <= 1'b1;
              mem_we     <= MemWrite;
              mem_addr   <= w_maddr;
              mem_wdata  <= w_wdata;
              mem_be     <= w_be;
              r_state    <= WAIT_ACK;
            end else begin
              out_valid    <= 1'b1;
              out_fault    <= 1'b0;
              out_RegWrite <= in_RegWrite;
            end
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            out_valid    <= 1'b1;
            out_data     <= r_is_load ? w_load : '0;
            out_RegWrite <= r_is_load & r_regwrite;
            r_state      <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized scoreboard bench for mem_stage_lsu: a byte-level reference model
// predicts RAM requests and writeback results; a RAM responder and monitor check them.
module tb_mem_stage_lsu;
  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [31:0]     addr, wdata;
  logic            MemRead, MemWrite;
  logic [2:0]      funct3;
  logic            in_RegWrite, in_MemToReg;
  logic [4:0]      in_RegDest;
  logic            mem_req, mem_we, mem_ack;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_be;
  logic            out_valid, out_RegWrite, out_MemToReg, out_fault;
  logic [31:0]     out_data, out_AluResult;
  logic [4:0]      out_RegDest;

  mem_stage_lsu #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .addr(addr), .wdata(wdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest), .in_MemToReg(in_MemToReg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_AluResult(out_AluResult),
    .out_RegWrite(out_RegWrite), .out_RegDest(out_RegDest),
    .out_MemToReg(out_MemToReg), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data; logic [31:0] alu; logic rw; logic [4:0] rd;
    logic m2r; logic fault; int unsigned at;
  } exp_t;
  typedef struct {
    logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
    logic [31:0] rdata; int unsigned delay;
  } mreq_t;

  exp_t  q_exp[$];
  mreq_t q_mem[$];
  bit    late_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_fault"}, out_fault, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_AluResult"}, out_AluResult, 0);
    chk({tag, "_out_RegWrite"}, out_RegWrite, 0);
    chk({tag, "_out_RegDest"}, out_RegDest, 0);
    chk({tag, "_out_MemToReg"}, out_MemToReg, 0);
  endtask

  // Reference model: decides legality, RAM request and writeback result per op.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic mr,
                       input logic mw, input logic [2:0] f3, input logic rw,
                       input logic [4:0] rd, input logic m2r, input logic [31:0] rdata,
                       input int unsigned dly);
    exp_t   e;
    mreq_t  m;
    int     nb, off;
    bit     bad;
    longint v;
    for (int unsigned k = 0; k < 100 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      chk("in_ready_wait", 0, 1);
      return;
    end
    nb  = 1 << f3[1:0];
    off = int'(a % 4);
    bad = (mr && mw) || (f3 == 3'd7) || (f3[1:0] == 2'd3) || (f3 == 3'd6) ||
          ((a % nb) != 0);
    e.alu = a; e.rd = rd; e.m2r = m2r; e.data = 0; e.fault = 0; e.rw = rw;
    e.at  = cyc + 1;
    if ((mr || mw) && bad) begin
      e.fault = 1; e.rw = 0;
    end else if (mr || mw) begin
      e.at    = cyc + 2 + dly;
      m.addr  = a - off;
      m.be    = 4'(((1 << nb) - 1) << off);
      m.we    = mw;
      m.wdata = 0;
      for (int k = 0; k < nb; k++) m.wdata[8*(off+k) +: 8] = wd[8*k +: 8];
      m.rdata = rdata;
      m.delay = dly;
      if (mw) e.rw = 0;
      else begin
        v = 0;
        for (int k = 0; k < nb; k++) v += longint'(rdata[8*(off+k) +: 8]) << (8*k);
        if (!f3[2] && v >= (longint'(1) << (8*nb-1))) v -= longint'(1) << (8*nb);
        e.data = v[31:0];
      end
      q_mem.push_back(m);
    end
    q_exp.push_back(e);
    in_valid = 1; addr = a; wdata = wd; MemRead = mr; MemWrite = mw; funct3 = f3;
    in_RegWrite = rw; in_RegDest = rd; in_MemToReg = m2r;
    @(negedge clk);
    in_valid = 0; MemRead = 0; MemWrite = 0;
  endtask

  task automatic drain();
    for (int unsigned k = 0; k < 300 && q_exp.size() != 0; k++) @(negedge clk);
    chk("drain_timeout", q_exp.size(), 0);
  endtask

  // Monitor
  exp_t me;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q_exp.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        me = q_exp.pop_front();
        chk("out_data", out_data, me.data);
        chk("out_AluResult", out_AluResult, me.alu);
        chk("out_RegWrite", out_RegWrite, me.rw);
        chk("out_RegDest", out_RegDest, me.rd);
        chk("out_MemToReg", out_MemToReg, me.m2r);
        chk("out_fault", out_fault, me.fault);
        chk("latency", cyc, me.at);
      end
    end
  end

  // RAM responder
  mreq_t       cur;
  bit          active = 1'b0;
  int unsigned cnt;
  logic [31:0] lm;
  always @(negedge clk) begin
    if (rst) begin
      active  = 0;
      mem_ack = 0;
      mem_rdata = 0;
    end else if (mem_req) begin
      if (!active) begin
        if (q_mem.size() == 0) begin
          chk("unexpected_mem_req", 1, 0);
          cur.addr = mem_addr; cur.be = mem_be; cur.we = mem_we;
          cur.wdata = mem_wdata; cur.rdata = 0; cur.delay = 0;
        end else cur = q_mem.pop_front();
        active = 1;
        cnt = cur.delay;
      end else if (cnt > 0) cnt--;
      for (int i = 0; i < 4; i++) lm[8*i +: 8] = {8{cur.be[i]}};
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_be", mem_be, cur.be);
      chk("mem_we", mem_we, cur.we);
      if (cur.we) chk("mem_wdata", mem_wdata & lm, cur.wdata & lm);
      chk("in_ready_busy", in_ready, 0);
      mem_ack   = (cnt == 0);
      mem_rdata = cur.rdata;
    end else begin
      active    = 0;
      mem_ack   = late_ack || ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic [2:0]  ld_f3 [5];
    int unsigned kind;
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
    rst = 1; in_valid = 0; addr = 0; wdata = 0; MemRead = 0; MemWrite = 0;
    funct3 = 0; in_RegWrite = 0; in_RegDest = 0; in_MemToReg = 0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    issue(32'h1234, 0, 0, 0, 3'b000, 1, 5'd7, 0, 0, 0);
    issue(32'h103, 0, 1, 0, 3'b000, 1, 5'd3, 1, 32'h80FF_FFFF, 3);
    issue(32'h202, 32'h0000_ABCD, 0, 1, 3'b001, 1, 5'd4, 0, 0, 1);
    issue(32'h301, 0, 1, 0, 3'b010, 1, 5'd5, 1, 0, 0);
    issue(32'h10, 0, 1, 0, 3'b101, 1, 5'd6, 1, 32'h0000_8001, 0);
    issue(32'h40, 32'h55, 1, 1, 3'b010, 1, 5'd8, 0, 0, 0);
    issue(32'h48, 0, 1, 0, 3'b011, 1, 5'd9, 1, 0, 0);
    issue(32'h48, 0, 1, 0, 3'b110, 1, 5'd10, 1, 0, 0);
    issue(32'h48, 0, 1, 0, 3'b111, 1, 5'd11, 1, 0, 0);
    issue(32'h7FC, 32'h1122_3344, 0, 1, 3'b010, 0, 5'd12, 0, 0, 2);
    issue(32'h7FE, 0, 1, 0, 3'b001, 1, 5'd13, 1, 32'h8765_4321, 0);
    drain();

    for (int unsigned n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      if (kind <= 2)
        issue(a, $urandom, 0, 0, 3'($urandom_range(0, 7)), 1'($urandom), 5'($urandom), 1'($urandom), 0, 0);
      else if (kind <= 6) begin
        f3 = ($urandom_range(0, 9) < 8) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
        issue(a, $urandom, 1, 0, f3, 1'($urandom), 5'($urandom), 1'($urandom), $urandom,
              $urandom_range(0, 4));
      end else if (kind <= 8)
        issue(a, $urandom, 0, 1, 3'($urandom_range(0, 2)), 1'($urandom), 5'($urandom),
              1'($urandom), $urandom, $urandom_range(0, 4));
      else
        issue(a, $urandom, 1, 1, 3'($urandom_range(0, 2)), 1, 5'($urandom), 1'($urandom), 0, 0);
    end
    drain();

    // Reset while waiting for a slow RAM acknowledge.
    issue(32'h500, 0, 1, 0, 3'b010, 1, 5'd14, 1, 32'hDEAD_BEEF, 20);
    repeat (2) @(negedge clk);
    chk("wait_ack_mem_req", mem_req, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    q_exp.delete();
    q_mem.delete();
    @(negedge clk);
    check_reset("mid_reset");
    rst = 0;
    late_ack = 1;
    @(negedge clk);
    chk("in_ready_after_mid_reset", in_ready, 1);
    for (int unsigned k = 0; k < 3; k++) begin
      chk("late_ack_mem_req", mem_req, 0);
      chk("late_ack_out_valid", out_valid, 0);
      @(negedge clk);
    end
    late_ack = 0;
    issue(32'h99, 0, 0, 0, 3'b000, 1, 5'd15, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
